// File: rtl/cache_burst_transfer_pkg.sv
// Shared types and size helpers for the cache block burst transfer unit.
package cache_burst_pkg;

  typedef enum logic [2:0] {IDLE, BEAT, GAP, DONE, FAULT} t_burst_state;
  typedef enum logic {DIR_READ, DIR_WRITE} t_dir;

  function automatic int WORDS(input int block_w, input int data_w);
    return block_w / data_w;
  endfunction

  // A single-word block still needs a 1-bit index so the vectors stay legal.
  function automatic int IDX_W(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

  function automatic int OFF_LO(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/cache_burst_transfer_if.sv
// Cache-side request/response and AXI-side beat signals of the burst transfer unit.
interface cache_burst_transfer_if #(
  parameter int BLOCK_WIDTH    = 512,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 64
);
  logic                      i_start_read;
  logic                      i_start_write;
  logic [AXI_ADDR_WIDTH-1:0] i_addr_cache;
  logic [BLOCK_WIDTH-1:0]    i_data_block_cache;
  logic [BLOCK_WIDTH-1:0]    o_data_block_cache;
  logic                      o_busy;
  logic                      o_done;
  logic                      o_fault;
  logic                      o_start_read_axi;
  logic                      o_start_write_axi;
  logic [AXI_ADDR_WIDTH-1:0] o_addr_axi;
  logic [AXI_DATA_WIDTH-1:0] o_data_axi;
  logic [AXI_DATA_WIDTH-1:0] i_data_axi;
  logic                      i_axi_done;
  logic                      i_read_fault;
  logic                      i_write_fault;

  modport slave (
    input  i_start_read, i_start_write, i_addr_cache, i_data_block_cache,
           i_data_axi, i_axi_done, i_read_fault, i_write_fault,
    output o_data_block_cache, o_busy, o_done, o_fault,
           o_start_read_axi, o_start_write_axi, o_addr_axi, o_data_axi
  );

  modport master (
    output i_start_read, i_start_write, i_addr_cache, i_data_block_cache,
           i_data_axi, i_axi_done, i_read_fault, i_write_fault,
    input  o_data_block_cache, o_busy, o_done, o_fault,
           o_start_read_axi, o_start_write_axi, o_addr_axi, o_data_axi
  );
endinterface

// File: rtl/cache_burst_transfer_addr_gen.sv
// Beat index with wrap, completed-beat counter and beat byte-address generation.
module burst_addr_gen #(
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int NWORDS         = 16,
  parameter int IW             = 4,
  parameter int OL             = 2
) (
  input  logic                      i_clk,
  input  logic                      i_arst,
  input  logic                      i_load,
  input  logic                      i_adv,
  input  logic [AXI_ADDR_WIDTH-1:0] i_base,
  input  logic [IW-1:0]             i_start_idx,
  output logic [IW-1:0]             o_idx,
  output logic                      o_last,
  output logic [AXI_ADDR_WIDTH-1:0] o_addr
);
  localparam int CW = IW + 1;

  logic [IW-1:0]             idx_q, idx_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [AXI_ADDR_WIDTH-1:0] base_q, base_d;

  always_comb begin
    idx_d  = idx_q;
    cnt_d  = cnt_q;
    base_d = base_q;
    if (i_load) begin
      idx_d  = i_start_idx;
      cnt_d  = '0;
      base_d = i_base;
    end else if (i_adv) begin
      idx_d = (idx_q == IW'(NWORDS - 1)) ? '0 : idx_q + IW'(1);
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_arst) begin
    if (!i_arst) begin
      idx_q  <= '0;
      cnt_q  <= '0;
      base_q <= '0;
    end else begin
      idx_q  <= idx_d;
      cnt_q  <= cnt_d;
      base_q <= base_d;
    end
  end

  // Current beat is the last one when every earlier beat has already completed.
  assign o_last = (cnt_q == CW'(NWORDS - 1));
  assign o_idx  = idx_q;
  assign o_addr = base_q + (AXI_ADDR_WIDTH'(idx_q) << OL);

endmodule

// File: rtl/cache_burst_transfer.sv
// Moves one cache block to/from the AXI4-Lite master as single-word beats, optionally critical-word-first.
module cache_burst_transfer
  import cache_burst_pkg::*;
#(
  parameter int BLOCK_WIDTH    = 512,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 64,
  parameter bit WRAP_EN        = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_arst,
  cache_burst_transfer_if.slave bus
);
  localparam int NWORDS  = WORDS(BLOCK_WIDTH, AXI_DATA_WIDTH);
  localparam int IW      = IDX_W(NWORDS);
  localparam int OL      = OFF_LO(AXI_DATA_WIDTH);
  localparam int BLK_OFF = $clog2(BLOCK_WIDTH / 8);
  localparam logic [AXI_ADDR_WIDTH-1:0] BASE_MASK =
    ~((AXI_ADDR_WIDTH'(1) << BLK_OFF) - AXI_ADDR_WIDTH'(1));

  t_burst_state              state_q, state_d;
  t_dir                      dir_q, dir_d;
  logic [BLOCK_WIDTH-1:0]    wblk_q, wblk_d, rbuf_q, rbuf_d, blk_q, blk_d;
  logic                      fault_q, fault_d;
  logic                      accept, beat_fault, beat_done, last;
  logic [IW-1:0]             idx, start_idx;
  logic [AXI_ADDR_WIDTH-1:0] beat_addr;

  assign accept     = (state_q == IDLE) && (bus.i_start_read || bus.i_start_write);
  // Only a fault from the active direction counts; it overrides a same-cycle done.
  assign beat_fault = (state_q == BEAT) &&
                      ((dir_q == DIR_READ) ? bus.i_read_fault : bus.i_write_fault);
  assign beat_done  = (state_q == BEAT) && bus.i_axi_done && !beat_fault;
  assign start_idx  = (WRAP_EN && NWORDS > 1) ? bus.i_addr_cache[OL +: IW] : '0;

  burst_addr_gen #(
    .AXI_ADDR_WIDTH(AXI_ADDR_WIDTH),
    .NWORDS        (NWORDS),
    .IW            (IW),
    .OL            (OL)
  ) u_addr_gen (
    .i_clk      (i_clk),
    .i_arst     (i_arst),
    .i_load     (accept),
    .i_adv      (beat_done),
    .i_base     (bus.i_addr_cache & BASE_MASK),
    .i_start_idx(start_idx),
    .o_idx      (idx),
    .o_last     (last),
    .o_addr     (beat_addr)
  );

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    wblk_d  = wblk_q;
    rbuf_d  = rbuf_q;
    blk_d   = blk_q;
    fault_d = fault_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d = BEAT;
        dir_d   = bus.i_start_read ? DIR_READ : DIR_WRITE;
        wblk_d  = bus.i_data_block_cache;
        fault_d = 1'b0;
      end
      BEAT: begin
        if (beat_fault) begin
          state_d = FAULT;
          fault_d = 1'b1;
        end else if (bus.i_axi_done) begin
          state_d = last ? DONE : GAP;
        end
      end
      GAP:         state_d = BEAT;
      DONE, FAULT: state_d = IDLE;
      default:     state_d = IDLE;
    endcase
    if (beat_done && dir_q == DIR_READ)
      rbuf_d[int'(idx)*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] = bus.i_data_axi;
    // Publish the merged buffer so the new block is visible during the done pulse.
    if (state_d == DONE && dir_q == DIR_READ)
      blk_d = rbuf_d;
  end

  always_ff @(posedge i_clk or negedge i_arst) begin
    if (!i_arst) begin
      state_q <= IDLE;
      dir_q   <= DIR_READ;
      wblk_q  <= '0;
      rbuf_q  <= '0;
      blk_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      wblk_q  <= wblk_d;
      rbuf_q  <= rbuf_d;
      blk_q   <= blk_d;
      fault_q <= fault_d;
    end
  end

  assign bus.o_busy             = (state_q != IDLE);
  assign bus.o_done             = (state_q == DONE) || (state_q == FAULT);
  assign bus.o_fault            = fault_q;
  assign bus.o_start_read_axi   = (state_q == BEAT) && (dir_q == DIR_READ);
  assign bus.o_start_write_axi  = (state_q == BEAT) && (dir_q == DIR_WRITE);
  assign bus.o_addr_axi         = beat_addr;
  assign bus.o_data_axi         = wblk_q[int'(idx)*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
  assign bus.o_data_block_cache = blk_q;

endmodule
